split_result_collector: RTL and testbench
=========================================

Name: split_result_collector

Overview:
- Downstream stage of the per-constraint split blocks. Each split block drives one combinational constraint bit (e.g. constraint_12).
- Gathers NUM_CONS constraint bits per candidate assignment through a valid/ready handshake.
- Through a 2-stage pipeline, reduces them to a satisfied flag, the lowest failing constraint index and a failure count.
- Keeps running pass/total statistics for the solver controller.

Parameters:
- NUM_CONS, 16, number of constraint bits per candidate (2..64).
- TAG_W, 8, width of the candidate tag carried alongside the bits.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  candidate bits valid.
- in_ready  output  1  stage accepts candidate.
- in_cons  input  NUM_CONS  constraint results; bit i = constraint i satisfied.
- in_tag  input  TAG_W  candidate identifier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_tag  output  TAG_W  tag of result.
- out_sat  output  1  all (unmasked) constraints satisfied.
- out_fail_idx  output  IDX_W  lowest index i with in_cons[i]==0; 0 when out_sat.
- out_fail_cnt  output  IDX_W+1  number of failing constraints.
- clr  input  1  synchronous clear of statistics counters.
- pass_cnt  output  CNT_W  results delivered with out_sat=1.
- total_cnt  output  CNT_W  results delivered.

Behaviour:
- IDX_W = $clog2(NUM_CONS).
- Reset values:
  - out_valid = 0; in_ready = 1.
  - out_tag, out_sat, out_fail_idx, out_fail_cnt = 0.
  - pass_cnt and total_cnt = 0.
  - Internal s1_valid = 0.
- Stage 1:
  - Registers in_cons and in_tag on the in_valid && in_ready handshake.
  - s1_valid is set by that handshake and cleared when stage 1 advances with no new input.
- Stage 2 (output register):
  - Loads the reduction of the stage-1 data when s1_valid && (!out_valid || out_ready).
  - Reduction: out_sat = &cons; out_fail_cnt = popcount(~cons); out_fail_idx = priority-encode of ~cons from LSB.
- Latency: 2 cycles from input handshake to out_valid, with no stalls.
- Throughput: 1 candidate per cycle while out_ready=1.
- in_ready = !s1_valid || !out_valid || out_ready. This is combinational from out_ready and may not depend on in_valid.
- Stall: while out_valid && !out_ready, all out_* hold stable and stage 1 holds. Once both are full, in_ready=0.
- A new input may be accepted in the same cycle stage 1 drains.
- No data loss or duplication under any valid/ready pattern.
- Counters:
  - On the out_valid && out_ready handshake, total_cnt += 1 and pass_cnt += out_sat.
  - Both saturate at 2^CNT_W-1; no wrap.
- clr:
  - Zeroes both counters next cycle and has priority over a coincident handshake; that result is not counted.
  - clr does not affect pipeline contents.
- Reset mid-operation: in-flight candidates are discarded, with no output handshake for them after reset release.
- in_cons all zeros (NUM_CONS=16) -> fail_idx=0, fail_cnt=16.

Optional Feature:
- Macro: SPLIT_COLLECT_MASK_EN.
- Defined:
  - Adds input in_mask [NUM_CONS], captured with in_cons.
  - A masked bit (in_mask[i]=1) is treated as satisfied for out_sat, out_fail_idx and out_fail_cnt.
- Undefined: no in_mask port; every constraint bit counts.

Decomposition:
- Package split_pkg holds:
  - the function clog2-based IDX_W helper;
  - the typedef for the reduced result struct {sat, fail_idx, fail_cnt};
  - the localparam for the counter saturation value.
- One sub-module, split_cons_reduce: combinational LSB-first priority encoder plus popcount, instantiated between stage 1 and stage 2.

Test Plan:
- Single candidate:
  - Stimulus: in_cons=16'hFFFF, tag=8'h05, out_ready=1.
  - Response: out_valid 2 cycles later, out_sat=1, fail_cnt=0, tag=05; pass_cnt=1, total_cnt=1.
- Failure encode:
  - Stimulus: in_cons=16'hFF5B.
  - Response: out_sat=0, fail_idx=2, fail_cnt=3.
  - Stimulus: in_cons=16'h0000.
  - Response: fail_idx=0, fail_cnt=16.
- Backpressure:
  - Stimulus: stream tags 1..6 with out_ready=0 for 5 cycles.
  - Response: in_ready drops after 2 accepts; outputs hold tag 1 stable. After release, tags 1..6 emerge in order with no gaps or duplicates.
- Counters:
  - Stimulus: assert clr in the same cycle as a passing handshake.
  - Response: pass_cnt=0, total_cnt=0 next cycle.
  - Stimulus: preload CNT_W=4 with 15 results.
  - Response: total_cnt holds at 15.
- Reset mid-stream:
  - Stimulus: drop rst_n with both stages full.
  - Response: out_valid=0 and in_ready=1 immediately; no stale output after release.
- Mask (SPLIT_COLLECT_MASK_EN):
  - Stimulus: in_cons=16'hFFFE, in_mask=16'h0001.
  - Response: out_sat=1, fail_cnt=0.

Source files
------------

// File: rtl/split_pkg.sv
// split_pkg: shared types and helpers for split_result_collector.
//   idx_w()     : width of a constraint index for a given constraint count
//   red_t       : reduced result {sat, fail_idx, fail_cnt}, sized for the
//                 largest supported constraint count (64)
//   CNT_SAT_ALL : all-ones saturation pattern, sliced to the counter width
package split_pkg;

  localparam int MAX_CONS  = 64;
  localparam int MAX_IDX_W = $clog2(MAX_CONS);
  localparam int MAX_CNT_W = 64;

  // Counters stop here instead of wrapping; users take the low CNT_W bits.
  localparam logic [MAX_CNT_W-1:0] CNT_SAT_ALL = '1;

  function automatic int idx_w(input int num_cons);
    return (num_cons > 1) ? $clog2(num_cons) : 1;
  endfunction

  typedef struct packed {
    logic                 sat;
    logic [MAX_IDX_W-1:0] fail_idx;
    logic [MAX_IDX_W:0]   fail_cnt;
  } red_t;

endpackage

// File: rtl/split_cons_reduce.sv
// split_cons_reduce: combinational reduction of one candidate's constraint bits.
//   i_cons : constraint results, bit i = constraint i satisfied
//   o_red  : sat = all bits set, fail_idx = lowest clear bit (0 if none),
//            fail_cnt = number of clear bits
module split_cons_reduce
  import split_pkg::*;
#(
  parameter int NUM_CONS = 16
) (
  input  logic [NUM_CONS-1:0] i_cons,
  output red_t                o_red
);

  localparam int CW = MAX_IDX_W + 1;

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    o_red     = '0;
    o_red.sat = &i_cons;
    // Scan from MSB down: the last failing bit written is the lowest one,
    // which gives the LSB-first priority without a separate found flag.
    for (int i = NUM_CONS - 1; i >= 0; i--) begin
      if (!i_cons[i]) begin
        o_red.fail_idx = MAX_IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CONS; i++) begin
      o_red.fail_cnt = o_red.fail_cnt + CW'(!i_cons[i]);
    end
  end

endmodule

// File: rtl/split_result_collector.sv
// split_result_collector: gathers per-candidate constraint bits from the split
// blocks and reduces them through a 2-stage valid/ready pipeline.
//   in_valid/in_ready/in_cons/in_tag     : candidate input handshake
//   out_valid/out_ready/out_tag/out_sat/out_fail_idx/out_fail_cnt : result
//   clr                                  : synchronous clear of statistics
//   pass_cnt/total_cnt                   : saturating result statistics
// Optional: define SPLIT_COLLECT_MASK_EN to add in_mask; a masked bit is
// treated as satisfied.
module split_result_collector
  import split_pkg::*;
#(
  parameter  int NUM_CONS = 16,
  parameter  int TAG_W    = 8,
  parameter  int CNT_W    = 32,
  localparam int IDX_W    = idx_w(NUM_CONS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_CONS-1:0] in_cons,
`ifdef SPLIT_COLLECT_MASK_EN
  input  logic [NUM_CONS-1:0] in_mask,
`endif
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_sat,
  output logic [IDX_W-1:0]    out_fail_idx,
  output logic [IDX_W:0]      out_fail_cnt,
  input  logic                clr,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    total_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_SAT_ALL[CNT_W-1:0];

  logic                r_s1_valid;
  logic [NUM_CONS-1:0] r_s1_cons;
  logic [TAG_W-1:0]    r_s1_tag;

  logic                r_out_valid;
  logic [TAG_W-1:0]    r_out_tag;
  logic                r_out_sat;
  logic [IDX_W-1:0]    r_out_fail_idx;
  logic [IDX_W:0]      r_out_fail_cnt;

  logic [CNT_W-1:0]    r_pass_cnt;
  logic [CNT_W-1:0]    r_total_cnt;

  logic                w_in_ready;
  logic                w_in_hs;
  logic                w_s2_load;
  logic                w_out_hs;
  logic [NUM_CONS-1:0] w_in_cons_eff;
  red_t                w_red;
  logic                w_red_unused;

`ifdef SPLIT_COLLECT_MASK_EN
  // Folding the mask in at capture time makes masked bits look satisfied.
  assign w_in_cons_eff = in_cons | in_mask;
`else
  assign w_in_cons_eff = in_cons;
`endif

  // Stage 1 can take a new candidate if it is empty, or if it will drain into
  // stage 2 this cycle. Depends only on state and out_ready, never in_valid.
  assign w_in_ready = !r_s1_valid || !r_out_valid || out_ready;
  assign w_in_hs    = in_valid && w_in_ready;
  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign w_out_hs   = r_out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // NOTE: stage-1 payload needs no reset; it is only consumed under
  // r_s1_valid, which is reset.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_s1_cons <= w_in_cons_eff;
      r_s1_tag  <= in_tag;
    end
  end

  split_cons_reduce #(
    .NUM_CONS (NUM_CONS)
  ) u_reduce (
    .i_cons (r_s1_cons),
    .o_red  (w_red)
  );

  // Bits above IDX_W are always zero for this NUM_CONS.
  assign w_red_unused = (|(w_red.fail_idx >> IDX_W)) || (|(w_red.fail_cnt >> (IDX_W + 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_tag      <= '0;
      r_out_sat      <= 1'b0;
      r_out_fail_idx <= '0;
      r_out_fail_cnt <= '0;
    end else if (w_s2_load) begin
      r_out_valid    <= 1'b1;
      r_out_tag      <= r_s1_tag;
      r_out_sat      <= w_red.sat;
      r_out_fail_idx <= w_red.fail_idx[IDX_W-1:0];
      r_out_fail_cnt <= w_red.fail_cnt[IDX_W:0];
    end else if (out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  // clr wins over a coincident handshake: that result is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt  <= '0;
      r_total_cnt <= '0;
    end else if (clr) begin
      r_pass_cnt  <= '0;
      r_total_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_total_cnt != CNT_MAX) begin
        r_total_cnt <= r_total_cnt + CNT_W'(1);
      end
      if (r_out_sat && (r_pass_cnt != CNT_MAX)) begin
        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_tag      = r_out_tag;
  assign out_sat      = r_out_sat;
  assign out_fail_idx = r_out_fail_idx;
  assign out_fail_cnt = r_out_fail_cnt;
  assign pass_cnt     = r_pass_cnt;
  assign total_cnt    = r_total_cnt;

endmodule

// File: tb/tb_split_result_collector.sv
// tb_split_result_collector: scoreboard bench for split_result_collector.
// Main instance uses default parameters; a second instance with CNT_W=4
// exercises counter saturation.
module tb_split_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_cons, in_mask;
  logic [7:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_sat, clr;
  logic [3:0]  out_fail_idx;
  logic [4:0]  out_fail_cnt;
  logic [31:0] pass_cnt, total_cnt;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_sat4;
  logic [7:0]  out_tag4;
  logic [3:0]  out_fail_idx4;
  logic [4:0]  out_fail_cnt4;
  logic [3:0]  pass_cnt4, total_cnt4;

  typedef struct {
    logic [7:0] tag;
    logic       sat;
    logic [3:0] idx;
    logic [4:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  split_result_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cons      (in_cons),
`ifdef SPLIT_COLLECT_MASK_EN
    .in_mask      (in_mask),
`endif
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tag      (out_tag),
    .out_sat      (out_sat),
    .out_fail_idx (out_fail_idx),
    .out_fail_cnt (out_fail_cnt),
    .clr          (clr),
    .pass_cnt     (pass_cnt),
    .total_cnt    (total_cnt)
  );

  split_result_collector #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid4),
    .in_ready     (in_ready4),
    .in_cons      (16'hFFFF),
`ifdef SPLIT_COLLECT_MASK_EN
    .in_mask      (16'h0000),
`endif
    .in_tag       (8'hA5),
    .out_valid    (out_valid4),
    .out_ready    (out_ready4),
    .out_tag      (out_tag4),
    .out_sat      (out_sat4),
    .out_fail_idx (out_fail_idx4),
    .out_fail_cnt (out_fail_cnt4),
    .clr          (1'b0),
    .pass_cnt     (pass_cnt4),
    .total_cnt    (total_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference reduction: LSB-first scan counting zeros of the effective bits.
  function automatic exp_t model(input logic [7:0] tag, input logic [15:0] cons,
                                 input logic [15:0] mask);
    exp_t        e;
    logic [15:0] eff;
    bit          found;
    eff   = cons | mask;
    e.tag = tag;
    e.sat = 1'b1;
    e.idx = '0;
    e.cnt = '0;
    found = 0;
    for (int i = 0; i < 16; i++) begin
      if (eff[i] == 1'b0) begin
        e.sat = 1'b0;
        e.cnt = e.cnt + 5'd1;
        if (!found) begin
          e.idx = 4'(i);
          found = 1;
        end
      end
    end
    return e;
  endfunction

  // Presents one candidate until it is accepted (bounded), then queues its
  // expected result.
  task automatic send(input logic [7:0] tag, input logic [15:0] cons, input logic [15:0] mask);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_tag   = tag;
    in_cons  = cons;
    in_mask  = mask;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", 64'(acc), 64'd1);
    if (acc) sb_q.push_back(model(tag, cons, mask));
    in_valid = 1'b0;
  endtask

  // Output monitor: every delivered result must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_sat", 64'(out_sat), 64'(e.sat));
        check("out_fail_idx", 64'(out_fail_idx), 64'(e.idx));
        check("out_fail_cnt", 64'(out_fail_cnt), 64'(e.cnt));
      end
    end
  end

  task automatic drain(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_cons    = '0;
    in_mask    = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    clr        = 1'b0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_fail_idx", 64'(out_fail_idx), 64'd0);
    check("rst_fail_cnt", 64'(out_fail_cnt), 64'd0);
    check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    check("rst_total_cnt", 64'(total_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single passing candidate, with 2-cycle latency.
    send(8'h05, 16'hFFFF, 16'h0000);
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    drain(3);
    check("single_pass_cnt", 64'(pass_cnt), 64'd1);
    check("single_total_cnt", 64'(total_cnt), 64'd1);

    // Failure encodes, streamed back to back.
    send(8'h10, 16'hFF5B, 16'h0000);
    send(8'h11, 16'h0000, 16'h0000);
    send(8'h12, 16'h8000, 16'h0000);
    send(8'h13, 16'h7FFF, 16'h0000);
    for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), 16'($urandom), 16'h0000);
    drain(4);

    // Backpressure: two accepts fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    send(8'd1, 16'hFFFF, 16'h0000);
    send(8'd2, 16'hFFF0, 16'h0000);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    fork
      begin
        send(8'd3, 16'h00FF, 16'h0000);
        send(8'd4, 16'hFFFF, 16'h0000);
        send(8'd5, 16'h1234, 16'h0000);
        send(8'd6, 16'hFFFE, 16'h0000);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_tag", 64'(out_tag), 64'd1);
          check("bp_hold_sat", 64'(out_sat), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(4);

    // clr coincident with a passing output handshake.
    send(8'h30, 16'hFFFF, 16'h0000);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("clr_out_seen", 64'(seen), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    check("clr_pass_cnt", 64'(pass_cnt), 64'd0);
    check("clr_total_cnt", 64'(total_cnt), 64'd0);
    send(8'h31, 16'hFFFF, 16'h0000);
    send(8'h32, 16'h0001, 16'h0000);
    drain(4);
    check("post_clr_pass_cnt", 64'(pass_cnt), 64'd1);
    check("post_clr_total_cnt", 64'(total_cnt), 64'd2);

`ifdef SPLIT_COLLECT_MASK_EN
    send(8'h40, 16'hFFFE, 16'h0001);
    send(8'h41, 16'h00F0, 16'hFF0F);
    send(8'h42, 16'hFF00, 16'h00F0);
    drain(4);
`endif

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'h50, 16'hFFFF, 16'h0000);
    send(8'h51, 16'h0F0F, 16'h0000);
    @(negedge clk);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_total_cnt", 64'(total_cnt), 64'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale_out", 64'(out_valid), 64'd0);
    end

    // Counter saturation on the 4-bit instance.
    @(posedge clk);
    #1;
    in_valid4 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("cnt4_mid_total", 64'(total_cnt4 >= 4'd5 && total_cnt4 <= 4'd7), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    check("cnt4_sat_total", 64'(total_cnt4), 64'd15);
    check("cnt4_sat_pass", 64'(pass_cnt4), 64'd15);
    repeat (3) @(posedge clk);
    #1;
    check("cnt4_hold_total", 64'(total_cnt4), 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
